// File: rtl/ppcm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ppcm_ctrl_pkg
// Shared definitions for the parallel PCM controller:
//   - state_t : controller state encoding (S_WRITE exists only when the
//               PPCM_WRITE_EN macro is defined)
//   - get_width  : number of bits needed to hold a non-negative value
//   - calc_count : converts a delay in ns into a cycle count at a given MHz
// ---------------------------------------------------------------------------
package ppcm_ctrl_pkg;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_WAIT  = 3'd2,
        S_READ  = 3'd3,
`ifdef PPCM_WRITE_EN
        S_WRITE = 3'd4,
`endif
        S_DONE  = 3'd5
    } state_t;

    localparam int HALF_BITS = 16;

    // Bits required to represent 'value' (at least one bit).
    function automatic int get_width(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((value >> i) != 0) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // Cycle count covering delay_ns at freq_mhz, rounded down, plus one.
    function automatic int calc_count(input int freq_mhz, input int delay_ns);
        return 32'sd1 + (freq_mhz * delay_ns) / 32'sd1000;
    endfunction

endpackage

// File: rtl/ppcm_delay_counter.sv
// ---------------------------------------------------------------------------
// ppcm_delay_counter
// Down-counter used to time every controller phase. A load sets the count;
// otherwise it decrements and parks at zero. tc is high while the count is 0.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val on the next edge (has priority)
//   load_val  : W-bit reload value
//   tc        : terminal count, count == 0
// ---------------------------------------------------------------------------
module ppcm_delay_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_r;

    // Load has priority, then count down until zero and hold there
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != '0) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == '0);

endmodule

// File: rtl/ppcm_ctrl.sv
// ---------------------------------------------------------------------------
// ppcm_ctrl
// Host-side controller for a 16-bit parallel PCM device. A host word of
// DATA_BITS is transferred as N = DATA_BITS/16 halfword beats, beat 0 being
// the least significant halfword. Reads may burst within a device page.
// Writes are compiled in only when the macro PPCM_WRITE_EN is defined.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   cs, we, burst   : request, write select, burst-read request
//   addr            : host word address (sampled in S_IDLE only)
//   din / dout      : write data / read data (dout valid while ack=1)
//   busy, ack       : controller not idle / one-cycle word-complete pulse
//   pcm_*           : device pins (active-low strobes, halfword address)
// All outputs are registered.
// ---------------------------------------------------------------------------
module ppcm_ctrl
    import ppcm_ctrl_pkg::*;
#(
    parameter int CLK_FREQ    = 100,
    parameter int ADDR_BITS   = 24,
    parameter int DATA_BITS   = 32,
    parameter int PAGE_WORDS  = 8,
    parameter int DELAY_INIT  = 100000,
    parameter int DELAY_START = 115,
    parameter int DELAY_DATA  = 25,
    parameter int DELAY_WE    = 60
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      cs,
    input  logic                                      we,
    input  logic [ADDR_BITS-$clog2(DATA_BITS/8)-1:0]  addr,
    input  logic                                      burst,
    input  logic [DATA_BITS-1:0]                      din,
    output logic [DATA_BITS-1:0]                      dout,
    output logic                                      busy,
    output logic                                      ack,
    output logic                                      pcm_ce_n,
    output logic                                      pcm_rst_n,
    output logic                                      pcm_oe_n,
    output logic                                      pcm_we_n,
    output logic [ADDR_BITS-2:0]                      pcm_addr,
    input  logic [15:0]                               pcm_din,
    output logic [15:0]                               pcm_dout
);

    localparam int NBEATS   = DATA_BITS / HALF_BITS;
    localparam int BEAT_SH  = $clog2(NBEATS);
    localparam int BEAT_W   = (NBEATS > 1) ? BEAT_SH : 1;
    localparam int PA_W     = ADDR_BITS - 1;

    localparam int COUNT_INIT  = calc_count(CLK_FREQ, DELAY_INIT);
    localparam int COUNT_START = calc_count(CLK_FREQ, DELAY_START);
    localparam int COUNT_DATA  = calc_count(CLK_FREQ, DELAY_DATA);
    localparam int COUNT_WE    = calc_count(CLK_FREQ, DELAY_WE);
    localparam int CNT_W       = get_width(COUNT_INIT - 1);

    // Reload values are "cycles - 1" because the counter spends one cycle at 0.
    localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(COUNT_INIT - 1);
    localparam logic [CNT_W-1:0] LD_WAIT = CNT_W'(COUNT_START - COUNT_DATA - 1);
    localparam logic [CNT_W-1:0] LD_DATA = CNT_W'(COUNT_DATA - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
    localparam logic [PA_W-1:0]   PAGE_MASK = PA_W'(PAGE_WORDS - 1);

    state_t               state_r, state_nxt_s;
    logic                 busy_r, busy_nxt_s;
    logic                 ack_r, ack_nxt_s;
    logic                 ack_pend_r, ack_pend_nxt_s;
    logic [DATA_BITS-1:0] dout_r, dout_nxt_s;
    logic                 ce_n_r, ce_n_nxt_s;
    logic                 oe_n_r, oe_n_nxt_s;
    logic [PA_W-1:0]      paddr_r, paddr_nxt_s;
    logic [BEAT_W-1:0]    beat_r, beat_nxt_s;
    logic                 pcm_rst_n_r;

    logic                 cnt_load_s;
    logic [CNT_W-1:0]     cnt_val_s;
    logic                 cnt_tc_s;

    logic [PA_W-1:0]      addr_start_s;
    logic [PA_W-1:0]      addr_inc_s;
    logic                 page_cont_s;

`ifdef PPCM_WRITE_EN
    logic                 we_n_r, we_n_nxt_s;
    logic [15:0]          pdout_r, pdout_nxt_s;
    logic [DATA_BITS-1:0] wdata_r, wdata_nxt_s;
    logic                 rec_r, rec_nxt_s;
    logic [BEAT_W-1:0]    beat_inc_s;
    localparam int        COUNT_WE_CHK = COUNT_WE;
    localparam logic [CNT_W-1:0] LD_WE = CNT_W'(COUNT_WE_CHK - 1);

    assign beat_inc_s = beat_r + BEAT_W'(1);
`else
    // Write path is absent: keep we/din/COUNT_WE visibly consumed.
    logic unused_ok_s;
    assign unused_ok_s = ^{we, din, COUNT_WE[0]};
`endif

    // Word address to halfword address: append log2(N) zero bits.
    assign addr_start_s = PA_W'(addr) << BEAT_SH;
    assign addr_inc_s   = paddr_r + PA_W'(1);
    assign page_cont_s  = ((addr_inc_s & PAGE_MASK) != '0);

    ppcm_delay_counter #(
        .W (CNT_W)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .tc       (cnt_tc_s)
    );

    // Next-state and next-output computation for the controller FSM
    always_comb begin
        state_nxt_s    = state_r;
        busy_nxt_s     = busy_r;
        ack_nxt_s      = ack_pend_r;
        ack_pend_nxt_s = 1'b0;
        dout_nxt_s     = dout_r;
        ce_n_nxt_s     = ce_n_r;
        oe_n_nxt_s     = oe_n_r;
        paddr_nxt_s    = paddr_r;
        beat_nxt_s     = beat_r;
        cnt_load_s     = 1'b0;
        cnt_val_s      = '0;
`ifdef PPCM_WRITE_EN
        we_n_nxt_s     = we_n_r;
        pdout_nxt_s    = pdout_r;
        wdata_nxt_s    = wdata_r;
        rec_nxt_s      = rec_r;
`endif
        case (state_r)
            S_INIT: begin
                // busy is still 0 only in the first cycle after reset,
                // which is where the power-up wait is armed.
                if (!busy_r) begin
                    busy_nxt_s = 1'b1;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = LD_INIT;
                end else if (cnt_tc_s) begin
                    state_nxt_s = S_IDLE;
                    busy_nxt_s  = 1'b0;
                end else begin
                    busy_nxt_s = 1'b1;
                end
            end
            S_IDLE: begin
                if (cs) begin
                    busy_nxt_s  = 1'b1;
                    ce_n_nxt_s  = 1'b0;
                    paddr_nxt_s = addr_start_s;
                    beat_nxt_s  = '0;
                    cnt_load_s  = 1'b1;
`ifdef PPCM_WRITE_EN
                    if (we) begin
                        state_nxt_s = S_WRITE;
                        we_n_nxt_s  = 1'b0;
                        pdout_nxt_s = din[15:0];
                        wdata_nxt_s = din;
                        rec_nxt_s   = 1'b0;
                        cnt_val_s   = LD_WE;
                    end else begin
                        state_nxt_s = S_WAIT;
                        oe_n_nxt_s  = 1'b0;
                        cnt_val_s   = LD_WAIT;
                    end
`else
                    state_nxt_s = S_WAIT;
                    oe_n_nxt_s  = 1'b0;
                    cnt_val_s   = LD_WAIT;
`endif
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_tc_s) begin
                    state_nxt_s = S_READ;
                    cnt_load_s  = 1'b1;
                    cnt_val_s   = LD_DATA;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_READ: begin
                if (cnt_tc_s) begin
                    dout_nxt_s[{beat_r, 4'h0} +: HALF_BITS] = pcm_din;
                    paddr_nxt_s = addr_inc_s;
                    cnt_load_s  = 1'b1;
                    cnt_val_s   = LD_DATA;
                    if (beat_r == LAST_BEAT) begin
                        beat_nxt_s     = '0;
                        ack_pend_nxt_s = 1'b1;
                        // Continue only inside the current device page.
                        if (cs && burst && page_cont_s) begin
                            state_nxt_s = S_READ;
                        end else begin
                            state_nxt_s = S_DONE;
                            busy_nxt_s  = 1'b0;
                            ce_n_nxt_s  = 1'b1;
                            oe_n_nxt_s  = 1'b1;
                            paddr_nxt_s = '0;
                        end
                    end else begin
                        beat_nxt_s = beat_r + BEAT_W'(1);
                    end
                end else begin
                    state_nxt_s = S_READ;
                end
            end
`ifdef PPCM_WRITE_EN
            S_WRITE: begin
                if (!cnt_tc_s) begin
                    state_nxt_s = S_WRITE;
                end else if (!rec_r) begin
                    // End of the we_n low phase: one recovery cycle,
                    // counter stays at 0 so tc is seen again next cycle.
                    we_n_nxt_s = 1'b1;
                    rec_nxt_s  = 1'b1;
                end else if (beat_r == LAST_BEAT) begin
                    state_nxt_s = S_DONE;
                    busy_nxt_s  = 1'b0;
                    ack_nxt_s   = 1'b1;
                    ce_n_nxt_s  = 1'b1;
                    we_n_nxt_s  = 1'b1;
                    paddr_nxt_s = '0;
                    pdout_nxt_s = 16'h0000;
                    beat_nxt_s  = '0;
                    rec_nxt_s   = 1'b0;
                end else begin
                    beat_nxt_s  = beat_inc_s;
                    paddr_nxt_s = addr_inc_s;
                    we_n_nxt_s  = 1'b0;
                    pdout_nxt_s = wdata_r[{beat_inc_s, 4'h0} +: HALF_BITS];
                    rec_nxt_s   = 1'b0;
                    cnt_load_s  = 1'b1;
                    cnt_val_s   = LD_WE;
                end
            end
`endif
            S_DONE: begin
                state_nxt_s = S_IDLE;
                busy_nxt_s  = 1'b0;
            end
            default: begin
                state_nxt_s = S_INIT;
                busy_nxt_s  = 1'b0;
                ce_n_nxt_s  = 1'b1;
                oe_n_nxt_s  = 1'b1;
                paddr_nxt_s = '0;
            end
        endcase
    end

    // Controller state and registered host/device outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_INIT;
            busy_r     <= 1'b0;
            ack_r      <= 1'b0;
            ack_pend_r <= 1'b0;
            dout_r     <= '0;
            ce_n_r     <= 1'b1;
            oe_n_r     <= 1'b1;
            paddr_r    <= '0;
            beat_r     <= '0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= busy_nxt_s;
            ack_r      <= ack_nxt_s;
            ack_pend_r <= ack_pend_nxt_s;
            dout_r     <= dout_nxt_s;
            ce_n_r     <= ce_n_nxt_s;
            oe_n_r     <= oe_n_nxt_s;
            paddr_r    <= paddr_nxt_s;
            beat_r     <= beat_nxt_s;
        end
    end

    // Device reset follows the host reset with one register stage
    always_ff @(posedge clk) begin
        pcm_rst_n_r <= ~rst;
    end

`ifdef PPCM_WRITE_EN
    // Write strobe, write data and write-phase bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            we_n_r  <= 1'b1;
            pdout_r <= 16'h0000;
            wdata_r <= '0;
            rec_r   <= 1'b0;
        end else begin
            we_n_r  <= we_n_nxt_s;
            pdout_r <= pdout_nxt_s;
            wdata_r <= wdata_nxt_s;
            rec_r   <= rec_nxt_s;
        end
    end

    assign pcm_we_n = we_n_r;
    assign pcm_dout = pdout_r;
`else
    assign pcm_we_n = 1'b1;
    assign pcm_dout = 16'h0000;
`endif

    assign dout      = dout_r;
    assign busy      = busy_r;
    assign ack       = ack_r;
    assign pcm_ce_n  = ce_n_r;
    assign pcm_oe_n  = oe_n_r;
    assign pcm_addr  = paddr_r;
    assign pcm_rst_n = pcm_rst_n_r;

endmodule

// File: tb/tb_ppcm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ppcm_ctrl
// Bench for ppcm_ctrl at 100 MHz: a 32-bit instance and a 64-bit instance
// share clk/rst and a combinational PCM data model. Expected read words are
// pushed to per-instance queues when a request is issued and popped on ack.
// Write checks are compiled according to PPCM_WRITE_EN.
// ---------------------------------------------------------------------------
module tb_ppcm_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        cs, we, burst;
    logic [21:0] addr;
    logic [31:0] din, dout;
    logic        busy, ack, ce_n, prst_n, oe_n, we_n;
    logic [22:0] paddr;
    logic [15:0] pdin, pdout;

    // 64-bit instance
    logic        cs64, we64, burst64;
    logic [20:0] addr64;
    logic [63:0] din64, dout64;
    logic        busy64, ack64, ce_n64, prst_n64, oe_n64, we_n64;
    logic [22:0] paddr64;
    logic [15:0] pdin64, pdout64;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp32_q[$];
    logic [63:0] exp64_q[$];
    logic [31:0] last_read32;

    // PCM contents: two fixed words, everything else derived from address.
    function automatic logic [15:0] model(input logic [22:0] a);
        if (a == 23'h000020) return 16'h1234;
        else if (a == 23'h000021) return 16'hABCD;
        else return {a[7:0] ^ 8'hA5, a[7:0]};
    endfunction

    assign pdin   = (!ce_n   && !oe_n)   ? model(paddr)   : 16'h0000;
    assign pdin64 = (!ce_n64 && !oe_n64) ? model(paddr64) : 16'h0000;

    ppcm_ctrl u_dut (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .burst(burst),
        .din(din), .dout(dout), .busy(busy), .ack(ack),
        .pcm_ce_n(ce_n), .pcm_rst_n(prst_n), .pcm_oe_n(oe_n), .pcm_we_n(we_n),
        .pcm_addr(paddr), .pcm_din(pdin), .pcm_dout(pdout)
    );

    ppcm_ctrl #(.DATA_BITS(64)) u_dut64 (
        .clk(clk), .rst(rst), .cs(cs64), .we(we64), .addr(addr64), .burst(burst64),
        .din(din64), .dout(dout64), .busy(busy64), .ack(ack64),
        .pcm_ce_n(ce_n64), .pcm_rst_n(prst_n64), .pcm_oe_n(oe_n64), .pcm_we_n(we_n64),
        .pcm_addr(paddr64), .pcm_din(pdin64), .pcm_dout(pdout64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs the power-up wait; cs of both instances dropped after drop_at samples.
    task automatic init_wait(input int drop_at, output int bc, output int bc64,
                             output bit pins_ok, output int acks, output logic rn_first);
        bc = 0; bc64 = 0; pins_ok = 1'b1; acks = 0; rn_first = 1'bx;
        for (int i = 0; i < 12000; i++) begin
            tick();
            if (i == 0) rn_first = prst_n;
            if (i == drop_at) begin cs = 1'b0; cs64 = 1'b0; end
            if (busy === 1'b1) bc++;
            if (busy64 === 1'b1) bc64++;
            if (ce_n !== 1'b1 || ce_n64 !== 1'b1) pins_ok = 1'b0;
            if (ack !== 1'b0 || ack64 !== 1'b0) acks++;
            if (busy !== 1'b1 && busy64 !== 1'b1 && bc > 0 && bc64 > 0) break;
        end
        cs = 1'b0; cs64 = 1'b0;
    endtask

    task automatic test_reset();
        int bc, bc64, acks; bit pins_ok; logic rn;
        rst = 1'b1; cs = 1'b0; we = 1'b0; burst = 1'b0; addr = '0; din = '0;
        cs64 = 1'b0; we64 = 1'b0; burst64 = 1'b0; addr64 = '0; din64 = '0;
        repeat (3) tick();
        tests_run++;
        if (busy !== 1'b0 || ack !== 1'b0 || dout !== 32'h0)
            begin tests_failed++; $display("FAIL reset_host: busy=%b ack=%b dout=%h required 0 0 0", busy, ack, dout); end
        tests_run++;
        if ({ce_n, oe_n, we_n} !== 3'b111 || paddr !== 23'h0 || pdout !== 16'h0 || prst_n !== 1'b0)
            begin tests_failed++; $display("FAIL reset_pins: ce/oe/we=%b addr=%h dout=%h rst_n=%b required 111 0 0 0", {ce_n, oe_n, we_n}, paddr, pdout, prst_n); end
        // Release reset with cs held high: the init wait must ignore it.
        rst = 1'b0; cs = 1'b1; cs64 = 1'b1;
        init_wait(5000, bc, bc64, pins_ok, acks, rn);
        tests_run++;
        if (bc !== 10001) begin tests_failed++; $display("FAIL init_busy_cycles: got %0d required 10001", bc); end
        tests_run++;
        if (bc64 !== 10001) begin tests_failed++; $display("FAIL init_busy_cycles64: got %0d required 10001", bc64); end
        tests_run++;
        if (!pins_ok || acks != 0) begin tests_failed++; $display("FAIL init_cs_ignored: pins_ok=%b acks=%0d required 1 0", pins_ok, acks); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL init_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_single_read(input logic [21:0] a);
        int first_ack, acks; logic [22:0] addr_a, addr_b; logic [31:0] expv, got;
        expv = {model({a, 1'b1}), model({a, 1'b0})};
        exp32_q.push_back(expv);
        cs = 1'b1; we = 1'b0; burst = 1'b0; addr = a;
        tick();                       // edge 0 samples cs
        cs = 1'b0; addr = ~a;         // later address changes must be ignored
        first_ack = 0; acks = 0; addr_a = '0; addr_b = '0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 11) addr_a = paddr;
            if (e == 14) addr_b = paddr;
            if (ack === 1'b1) begin
                acks++;
                if (first_ack == 0) first_ack = e;
                tests_run++;
                if (exp32_q.size() == 0) begin
                    tests_failed++; $display("FAIL read_unexpected_ack: edge %0d", e);
                end else begin
                    got = exp32_q.pop_front();
                    if (dout !== got) begin tests_failed++; $display("FAIL read_data: got %h required %h", dout, got); end
                    last_read32 = got;
                end
            end
        end
        tests_run++;
        if (first_ack != 16 || acks != 1) begin tests_failed++; $display("FAIL read_ack_timing: edge %0d count %0d required 16 1", first_ack, acks); end
        tests_run++;
        if (addr_a !== {a, 1'b0} || addr_b !== {a, 1'b1})
            begin tests_failed++; $display("FAIL read_pcm_addr: got %h %h required %h %h", addr_a, addr_b, {a, 1'b0}, {a, 1'b1}); end
        tests_run++;
        if (busy !== 1'b0 || ce_n !== 1'b1 || oe_n !== 1'b1 || paddr !== 23'h0)
            begin tests_failed++; $display("FAIL read_release: busy=%b ce=%b oe=%b addr=%h required 0 1 1 0", busy, ce_n, oe_n, paddr); end
    endtask

    task automatic test_burst();
        int acks, ack_e0, ack_e1, done_e; bit rel_ok; logic [31:0] got;
        exp32_q.push_back({model(23'h5), model(23'h4)});
        exp32_q.push_back({model(23'h7), model(23'h6)});
        cs = 1'b1; burst = 1'b1; we = 1'b0; addr = 22'h2;
        tick();
        addr = 22'h3F;
        acks = 0; ack_e0 = 0; ack_e1 = 0; done_e = 0; rel_ok = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (ack === 1'b1) begin
                acks++;
                if (acks == 1) ack_e0 = e; else ack_e1 = e;
                tests_run++;
                if (exp32_q.size() == 0) begin
                    tests_failed++; $display("FAIL burst_extra_ack: edge %0d", e);
                end else begin
                    got = exp32_q.pop_front();
                    if (dout !== got) begin tests_failed++; $display("FAIL burst_data: got %h required %h", dout, got); end
                    last_read32 = got;
                end
            end
            if (busy === 1'b0 && done_e == 0) begin
                done_e = e;
                rel_ok = (ce_n === 1'b1 && oe_n === 1'b1 && paddr === 23'h0);
                cs = 1'b0; burst = 1'b0;
            end
        end
        tests_run++;
        if (acks != 2 || ack_e0 != 16 || ack_e1 != 22)
            begin tests_failed++; $display("FAIL burst_acks: count %0d edges %0d %0d required 2 16 22", acks, ack_e0, ack_e1); end
        tests_run++;
        if (done_e != 21 || !rel_ok) begin tests_failed++; $display("FAIL burst_page_stop: edge %0d release %b required 21 1", done_e, rel_ok); end
    endtask

    task automatic test_wide_read();
        int acks, first_ack; logic [63:0] got;
        exp64_q.push_back({model(23'h17), model(23'h16), model(23'h15), model(23'h14)});
        cs64 = 1'b1; burst64 = 1'b0; we64 = 1'b0; addr64 = 21'h5;
        tick();
        cs64 = 1'b0;
        acks = 0; first_ack = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (ack64 === 1'b1) begin
                acks++;
                if (first_ack == 0) first_ack = e;
                tests_run++;
                if (exp64_q.size() == 0) begin
                    tests_failed++; $display("FAIL wide_extra_ack: edge %0d", e);
                end else begin
                    got = exp64_q.pop_front();
                    if (dout64 !== got) begin tests_failed++; $display("FAIL wide_data: got %h required %h", dout64, got); end
                end
            end
        end
        tests_run++;
        if (acks != 1 || first_ack != 22) begin tests_failed++; $display("FAIL wide_ack_timing: count %0d edge %0d required 1 22", acks, first_ack); end
    endtask

    task automatic test_write();
        int pulses, run, len1, len2, acks; logic [15:0] d1, d2; logic [22:0] a1;
        bit quiet_ok; logic [31:0] got;
        pulses = 0; run = 0; len1 = 0; len2 = 0; acks = 0; d1 = '0; d2 = '0; a1 = '0; quiet_ok = 1'b1;
`ifndef PPCM_WRITE_EN
        exp32_q.push_back({model(23'h11), model(23'h10)});
`endif
        cs = 1'b1; we = 1'b1; burst = 1'b0; addr = 22'h8; din = 32'hCAFEF00D;
        for (int e = 0; e <= 30; e++) begin
            tick();
            if (e == 0) begin cs = 1'b0; we = 1'b0; end
            if (we_n === 1'b0) begin
                if (run == 0) begin
                    pulses++;
                    if (pulses == 1) begin d1 = pdout; a1 = paddr; end else d2 = pdout;
                end
                run++;
            end else if (run > 0) begin
                if (pulses == 1) len1 = run; else len2 = run;
                run = 0;
            end
            if (we_n !== 1'b0 && pdout !== 16'h0 && run == 0 && pulses == 0) quiet_ok = 1'b0;
            if (ack === 1'b1) begin
                acks++;
`ifndef PPCM_WRITE_EN
                tests_run++;
                if (exp32_q.size() == 0) begin
                    tests_failed++; $display("FAIL nowrite_extra_ack: edge %0d", e);
                end else begin
                    got = exp32_q.pop_front();
                    if (dout !== got) begin tests_failed++; $display("FAIL nowrite_read_data: got %h required %h", dout, got); end
                    last_read32 = got;
                end
`endif
            end
        end
        din = '0;
`ifdef PPCM_WRITE_EN
        tests_run++;
        if (pulses != 2 || len1 != 7 || len2 != 7)
            begin tests_failed++; $display("FAIL write_pulses: count %0d len %0d %0d required 2 7 7", pulses, len1, len2); end
        tests_run++;
        if (d1 !== 16'hF00D || d2 !== 16'hCAFE || a1 !== 23'h10)
            begin tests_failed++; $display("FAIL write_data: got %h %h addr %h required f00d cafe 10", d1, d2, a1); end
        tests_run++;
        if (acks != 1 || dout !== last_read32)
            begin tests_failed++; $display("FAIL write_ack_dout: acks %0d dout %h required 1 %h", acks, dout, last_read32); end
`else
        tests_run++;
        if (pulses != 0 || !quiet_ok || pdout !== 16'h0)
            begin tests_failed++; $display("FAIL nowrite_we_n: pulses %0d quiet %b required 0 1", pulses, quiet_ok); end
        tests_run++;
        if (acks != 1) begin tests_failed++; $display("FAIL nowrite_acks: got %0d required 1", acks); end
`endif
    endtask

    task automatic test_reset_mid_read();
        int bc, bc64, acks; bit pins_ok; logic rn;
        acks = 0;
        cs = 1'b1; we = 1'b0; burst = 1'b0; addr = 22'h7;
        tick();
        cs = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (ack === 1'b1) acks++;
        end
        rst = 1'b1;
        tick();                       // reset sampled while in S_READ
        rst = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || prst_n !== 1'b0 || ce_n !== 1'b1 || ack !== 1'b0)
            begin tests_failed++; $display("FAIL midrst_state: busy=%b rst_n=%b ce=%b ack=%b required 0 0 1 0", busy, prst_n, ce_n, ack); end
        init_wait(-1, bc, bc64, pins_ok, acks, rn);
        tests_run++;
        if (rn !== 1'b1) begin tests_failed++; $display("FAIL midrst_rst_n_width: rst_n=%b required 1", rn); end
        tests_run++;
        if (bc != 10001 || acks != 0 || !pins_ok)
            begin tests_failed++; $display("FAIL midrst_init: busy cycles %0d acks %0d pins %b required 10001 0 1", bc, acks, pins_ok); end
        test_single_read(22'h33);
    endtask

    initial begin
        test_reset();
        test_single_read(22'h10);
        test_burst();
        test_wide_read();
        test_write();
        test_reset_mid_read();
        tests_run++;
        if (exp32_q.size() != 0 || exp64_q.size() != 0)
            begin tests_failed++; $display("FAIL scoreboard_drain: left %0d %0d required 0 0", exp32_q.size(), exp64_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
